// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
package mc_control_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned ALU_OP_W = 6;
   localparam int unsigned PERF_W   = 32;

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD,
      MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP
   } state_t;

   // Opcodes, IR[31:26]
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

   localparam logic [ALU_OP_W-1:0] ALU_ADD   = 6'b000000;
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = 6'b000001;
   localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 6'b000010;

   localparam logic       IORD_PC      = 1'b0;
   localparam logic       IORD_ALUOUT  = 1'b1;
   localparam logic [1:0] PC_SRC_ALU   = 2'd0;
   localparam logic [1:0] PC_SRC_OUT   = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP  = 2'd2;
   localparam logic [1:0] REG_DST_RT   = 2'd0;
   localparam logic [1:0] REG_DST_RD   = 2'd1;
   localparam logic [1:0] REG_DST_RA   = 2'd2;
   localparam logic [1:0] WB_ALUOUT    = 2'd0;
   localparam logic [1:0] WB_MDR       = 2'd1;
   localparam logic [1:0] WB_PC        = 2'd2;
   localparam logic       SRC_A_PC     = 1'b0;
   localparam logic       SRC_A_RS     = 1'b1;
   localparam logic [1:0] SRC_B_RT     = 2'd0;
   localparam logic [1:0] SRC_B_FOUR   = 2'd1;
   localparam logic [1:0] SRC_B_IMM    = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

endpackage

// File: rtl/mc_control_dispatch.sv
// Combinational opcode-to-state map used in DECODE, plus the legality check.
module mc_control_dispatch
   import mc_control_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   output state_t          next_state_c,
   output logic            legal_c
);

   always_comb begin
      next_state_c = TRAP;
      legal_c      = 1'b1;
      case (opcode)
         OP_RTYPE:                              next_state_c = EXEC_R;
         OP_ADDI, OP_ADDIU, OP_ORI, OP_ANDI,
         OP_SLTI, OP_SLTIU:                     next_state_c = EXEC_I;
         OP_LW, OP_SW:                          next_state_c = MEM_ADDR;
         OP_BEQ, OP_BNE:                        next_state_c = BRANCH;
         OP_J, OP_JAL:                          next_state_c = JUMP;
         default: begin
            next_state_c = TRAP;
            legal_c      = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control sequencer for the MIPS core (Moore FSM with mem_ready/alu_zero gating).
// Define MC_CONTROL_PERF_EN to build the retired-instruction and cycle counters.
module mc_control
   import mc_control_pkg::*;
(
   input  logic                clk,
   input  logic                nrst,
   input  logic [OP_W-1:0]     opcode,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                mem_read,
   output logic                mem_write,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                reg_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                instr_done,
   output logic                illegal,
   output logic [PERF_W-1:0]   perf_instr,
   output logic [PERF_W-1:0]   perf_cycles
);

   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q;
   state_t          disp_state_c;
   logic            disp_legal_c;

   mc_control_dispatch u_dispatch (
      .opcode       (opcode),
      .next_state_c (disp_state_c),
      .legal_c      (disp_legal_c)
   );

   // State register and opcode latch (captured on the way out of DECODE)
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE) op_q <= opcode;
      end
   end

   // Next state and datapath controls; everything stays at defaults while in reset
   always_comb begin
      state_d    = state_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = IORD_PC;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_ALU;
      reg_write  = 1'b0;
      reg_dst    = REG_DST_RT;
      mem_to_reg = WB_ALUOUT;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RT;
      alu_op     = ALU_FUNCT;
      instr_done = 1'b0;
      illegal    = 1'b0;
      if (nrst) begin
         case (state_q)
            FETCH: begin
               mem_read  = 1'b1;
               iord      = IORD_PC;
               alu_src_a = SRC_A_PC;
               alu_src_b = SRC_B_FOUR;
               alu_op    = ALU_ADD;
               pc_src    = PC_SRC_ALU;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = DECODE;
               end
            end
            DECODE: begin
               alu_src_a = SRC_A_PC;
               alu_src_b = SRC_B_IMM_SH;
               alu_op    = ALU_ADD;
               state_d   = disp_legal_c ? disp_state_c : TRAP;
            end
            EXEC_R: begin
               alu_src_a = SRC_A_RS;
               alu_src_b = SRC_B_RT;
               alu_op    = ALU_FUNCT;
               state_d   = WB_ALU;
            end
            EXEC_I: begin
               alu_src_a = SRC_A_RS;
               alu_src_b = SRC_B_IMM;
               alu_op    = (op_q == OP_ADDI || op_q == OP_ADDIU) ? ALU_ADD : op_q;
               state_d   = WB_ALU;
            end
            WB_ALU: begin
               reg_write  = 1'b1;
               reg_dst    = (op_q == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
               mem_to_reg = WB_ALUOUT;
               instr_done = 1'b1;
               state_d    = FETCH;
            end
            MEM_ADDR: begin
               alu_src_a = SRC_A_RS;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_ADD;
               state_d   = (op_q == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
               mem_read = 1'b1;
               iord     = IORD_ALUOUT;
               if (mem_ready) state_d = WB_MEM;
            end
            MEM_WR: begin
               mem_write = 1'b1;
               iord      = IORD_ALUOUT;
               if (mem_ready) begin
                  instr_done = 1'b1;
                  state_d    = FETCH;
               end
            end
            WB_MEM: begin
               reg_write  = 1'b1;
               reg_dst    = REG_DST_RT;
               mem_to_reg = WB_MDR;
               instr_done = 1'b1;
               state_d    = FETCH;
            end
            BRANCH: begin
               alu_src_a  = SRC_A_RS;
               alu_src_b  = SRC_B_RT;
               alu_op     = ALU_SUB;
               pc_src     = PC_SRC_OUT;
               pc_write   = (op_q == OP_BEQ) ? alu_zero : !alu_zero;
               instr_done = 1'b1;
               state_d    = FETCH;
            end
            JUMP: begin
               pc_write   = 1'b1;
               pc_src     = PC_SRC_JUMP;
               instr_done = 1'b1;
               if (op_q == OP_JAL) begin
                  reg_write  = 1'b1;
                  reg_dst    = REG_DST_RA;
                  mem_to_reg = WB_PC;
               end
               state_d = FETCH;
            end
            TRAP: begin
               illegal = 1'b1;
               state_d = TRAP;
            end
            default: state_d = TRAP;
         endcase
      end
   end

`ifdef MC_CONTROL_PERF_EN
   logic [PERF_W-1:0] instr_q, cycles_q;

   // Free-running counters, wrap modulo 2^32
   always_ff @(posedge clk) begin
      if (!nrst) begin
         instr_q  <= '0;
         cycles_q <= '0;
      end else begin
         cycles_q <= cycles_q + PERF_W'(1);
         if (instr_done) instr_q <= instr_q + PERF_W'(1);
      end
   end

   assign perf_instr  = instr_q;
   assign perf_cycles = cycles_q;
`else
   assign perf_instr  = '0;
   assign perf_cycles = '0;
`endif

endmodule
